pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch/decode/execute sequencer for the 16-bit RISC core. Owns the PC control pins (ld, inc),
//  the IR load strobe, the instruction-memory read handshake and the execution-unit start/done
//  handshake. Sits between the instruction memory, the PC and the CPU execution unit.
//  Resolves conditional branches from ALU flags and halts on HLT until restarted.
// PARAMETERS
//  MEM_TIMEOUT  16  FETCH cycles without mem_ack before fault (used only with PC_SEQ_TIMEOUT_EN)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-low reset
//  ir_op      in   4  opcode field of the current IR (valid from DECODE onward)
//  flag_z     in   1  ALU zero flag
//  flag_n     in   1  ALU negative flag
//  mem_ack    in   1  instruction memory data valid (sampled in FETCH only)
//  eu_done    in   1  execution unit finished (sampled in EXEC_WAIT only)
//  go         in   1  restart request (sampled in HALT only)
//  mem_rd     out  1  instruction read request
//  ir_ld      out  1  load IR from memory data
//  pc_inc     out  1  to PC inc
//  pc_ld      out  1  to PC ld (branch target on PC D_in)
//  eu_start   out  1  one-cycle start pulse to execution unit
//  halted     out  1  sequencer in HALT
//  fault      out  1  fetch timeout occurred (constant 0 without PC_SEQ_TIMEOUT_EN)
//  state      out  3  current state encoding (debug)
// BEHAVIOUR
//  - States: RST_WAIT=0, FETCH=1, DECODE=2, EXEC_START=3, EXEC_WAIT=4, BRANCH=5, HALT=6; 7 unused -> RST_WAIT.
//  - rst=0: state=RST_WAIT immediately; fault=0; all outputs 0 while in RST_WAIT.
//  - RST_WAIT: always -> FETCH next cycle (one idle cycle after reset release).
//  - FETCH: mem_rd=1. mem_ack=0: stay. mem_ack=1: ir_ld=1, pc_inc=1 same cycle (combinational), -> DECODE.
//  - DECODE: no outputs. ir_op 0x0-0xB -> EXEC_START; 0xC/0xD/0xE -> BRANCH; 0xF -> HALT.
//  - EXEC_START: eu_start=1 for exactly one cycle, -> EXEC_WAIT.
//  - EXEC_WAIT: eu_done=1 -> FETCH; else stay (no bound on wait).
//  - BRANCH (1 cycle, -> FETCH): pc_ld=1 iff taken: 0xC JMP always; 0xD BZ if flag_z; 0xE BN if flag_n.
//    Flags sampled in the BRANCH cycle. Not-taken: no outputs.
//  - HALT: halted=1. go=1 -> FETCH and fault cleared; go=0 -> stay.
//  - pc_ld and pc_inc never asserted in the same cycle; pc_inc never asserted outside FETCH.
//  - mem_ack outside FETCH, eu_done outside EXEC_WAIT, go outside HALT: ignored.
//  - Latency (mem_ack and eu_done immediate): ALU instr 4 cycles, branch 3, HLT reaches HALT in 2.
//  - Control outputs are decoded from state (+mem_ack in FETCH); state is the only register besides fault/counter.
//  - Reset asserted mid-instruction: abandon it, outputs drop to 0 asynchronously with state.
// CONFIGURATION
//  - PC_SEQ_TIMEOUT_EN defined: counter (width $clog2(MEM_TIMEOUT)+1) cleared on FETCH entry and
//    on mem_ack, +1 each FETCH cycle with mem_ack=0. If mem_ack is still 0 in the MEM_TIMEOUT-th
//    consecutive FETCH cycle: -> HALT, fault=1 (registered, held until go in HALT or rst). No pc_inc/ir_ld.
//  - Undefined: no counter, FETCH waits forever; fault tied to 0.
// TESTING
//  - Reset: rst=0 mid EXEC_WAIT -> state=0, all outputs 0; release -> 1 idle cycle, then mem_rd=1.
//  - ALU op 0x3, mem_ack held 1, eu_done=1 first wait cycle -> states 1,2,3,4,1; one pc_inc, one eu_start.
//  - mem_ack delayed 3 cycles -> mem_rd held 3+1 cycles, ir_ld/pc_inc only in the ack cycle.
//  - BZ 0xD with flag_z=1 -> pc_ld=1 in BRANCH, pc_inc=0; flag_z=0 -> no pc_ld, back to FETCH.
//  - HLT 0xF -> halted=1, go=0 for 10 cycles stays; go=1 -> FETCH next cycle, halted=0.
//  - PC_SEQ_TIMEOUT_EN, MEM_TIMEOUT=4, mem_ack=0 -> HALT after 4 FETCH cycles, fault=1; go clears fault.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer: drives PC, IR, instruction-memory and execution-unit handshakes.
// Optional fetch timeout fault enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ir_op,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       mem_ack,
    input  logic       eu_done,
    input  logic       go,
    output logic       mem_rd,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       eu_start,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        RST_WAIT   = 3'd0,
        FETCH      = 3'd1,
        DECODE     = 3'd2,
        EXEC_START = 3'd3,
        EXEC_WAIT  = 3'd4,
        BRANCH     = 3'd5,
        HALT       = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   fault_q, fault_d;
    logic   timeout_c;

`ifdef PC_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Last permitted FETCH cycle reached with no acknowledge.
    assign timeout_c = (state_q == FETCH) && !mem_ack &&
                       (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // Counts consecutive un-acked FETCH cycles; restarts on every FETCH entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == FETCH) begin
            cnt_d = mem_ack ? '0 : cnt_q + CNT_W'(1);
        end
        if (state_d == FETCH && state_q != FETCH) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign timeout_c      = 1'b0;
    assign unused_timeout = 32'(CNT_W) ^ 32'(MEM_TIMEOUT);
`endif

    // Next-state and control decode; ir_ld/pc_inc follow mem_ack within the FETCH cycle.
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        mem_rd   = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        eu_start = 1'b0;
        halted   = 1'b0;
        case (state_q)
            RST_WAIT: state_d = FETCH;
            FETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = DECODE;
                end else if (timeout_c) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end
            end
            DECODE: begin
                if (ir_op == 4'hF) begin
                    state_d = HALT;
                end else if (ir_op >= 4'hC) begin
                    state_d = BRANCH;
                end else begin
                    state_d = EXEC_START;
                end
            end
            EXEC_START: begin
                eu_start = 1'b1;
                state_d  = EXEC_WAIT;
            end
            EXEC_WAIT: begin
                if (eu_done) begin
                    state_d = FETCH;
                end
            end
            BRANCH: begin
                case (ir_op)
                    4'hC:    pc_ld = 1'b1;
                    4'hD:    pc_ld = flag_z;
                    4'hE:    pc_ld = flag_n;
                    default: pc_ld = 1'b0;
                endcase
                state_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (go) begin
                    fault_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST_WAIT;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

`ifdef PC_SEQ_TIMEOUT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (timeout checks follow PC_SEQ_TIMEOUT_EN).
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ir_op;
    logic       flag_z, flag_n, mem_ack, eu_done, go;
    logic       mem_rd, ir_ld, pc_inc, pc_ld, eu_start, halted, fault;
    logic [2:0] state;
    logic [6:0] outs;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ir_op(ir_op), .flag_z(flag_z), .flag_n(flag_n),
        .mem_ack(mem_ack), .eu_done(eu_done), .go(go),
        .mem_rd(mem_rd), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
        .eu_start(eu_start), .halted(halted), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    assign outs = {mem_rd, ir_ld, pc_inc, pc_ld, eu_start, halted, fault};

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_RD    = 7'b1000000;
    localparam logic [6:0] O_ACK   = 7'b1110000;
    localparam logic [6:0] O_PCLD  = 7'b0001000;
    localparam logic [6:0] O_START = 7'b0000100;
    localparam logic [6:0] O_HALT  = 7'b0000010;
    localparam logic [6:0] O_FLT   = 7'b0000011;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check state/outputs for the current cycle (inputs already applied), then advance one clock.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] o);
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_outs"}, 32'(outs), 32'(o));
        @(posedge clk);
        #2;
    endtask

    // Branch table: opcode, flag_z, flag_n, taken
    logic [3:0] br_op [5] = '{4'hD, 4'hD, 4'hC, 4'hE, 4'hE};
    logic       br_z  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       br_n  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       br_tk [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b0; ir_op = 4'h0; flag_z = 1'b0; flag_n = 1'b0;
        mem_ack = 1'b0; eu_done = 1'b0; go = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        cyc("reset", 3'd0, O_NONE);
        rst = 1'b1;
        cyc("idle", 3'd0, O_NONE);

        // ALU op with immediate ack and done: FETCH, DECODE, EXEC_START, EXEC_WAIT
        mem_ack = 1'b1; ir_op = 4'h3; eu_done = 1'b1;
        cyc("alu_f", 3'd1, O_ACK);
        mem_ack = 1'b0;
        cyc("alu_d", 3'd2, O_NONE);
        cyc("alu_s", 3'd3, O_START);
        cyc("alu_w", 3'd4, O_NONE);
        eu_done = 1'b0;

        // Delayed ack: three waiting read cycles, then ack
        for (int i = 0; i < 3; i++) cyc("dly_wait", 3'd1, O_RD);
        mem_ack = 1'b1; ir_op = 4'h8;
        cyc("dly_ack", 3'd1, O_ACK);
        mem_ack = 1'b0;
        cyc("dly_d", 3'd2, O_NONE);
        cyc("dly_s", 3'd3, O_START);
        eu_done = 1'b1;
        cyc("dly_w", 3'd4, O_NONE);
        eu_done = 1'b0;

        // Branches; go/eu_done raised around them must be ignored
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'b1; ir_op = br_op[i]; flag_z = br_z[i]; flag_n = br_n[i];
            cyc("br_f", 3'd1, O_ACK);
            mem_ack = 1'b0; go = 1'b1; eu_done = 1'b1;
            cyc("br_d", 3'd2, O_NONE);
            cyc("br_x", 3'd5, br_tk[i] ? O_PCLD : O_NONE);
            go = 1'b0; eu_done = 1'b0;
        end
        flag_z = 1'b0; flag_n = 1'b0;

        // Reset in the middle of EXEC_WAIT
        mem_ack = 1'b1; ir_op = 4'h5;
        cyc("rw_f", 3'd1, O_ACK);
        mem_ack = 1'b0;
        cyc("rw_d", 3'd2, O_NONE);
        cyc("rw_s", 3'd3, O_START);
        cyc("rw_w0", 3'd4, O_NONE);
        cyc("rw_w1", 3'd4, O_NONE);
        rst = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_outs", 32'(outs), 32'(O_NONE));
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc("rel_idle", 3'd0, O_NONE);
        mem_ack = 1'b1; ir_op = 4'hF;
        cyc("hlt_f", 3'd1, O_ACK);
        mem_ack = 1'b0;
        cyc("hlt_d", 3'd2, O_NONE);

        // HALT holds while go=0
        for (int i = 0; i < 10; i++) cyc("halt_hold", 3'd6, O_HALT);
        go = 1'b1;
        cyc("halt_go", 3'd6, O_HALT);
        go = 1'b0;
        cyc("after_go", 3'd1, O_RD);

`ifdef PC_SEQ_TIMEOUT_EN
        // after_go was FETCH cycle 1; cycles 2..4 with no ack, timeout on the 4th
        for (int i = 0; i < 3; i++) cyc("to_wait", 3'd1, O_RD);
        cyc("to_halt", 3'd6, O_FLT);
        cyc("to_hold", 3'd6, O_FLT);
        go = 1'b1;
        cyc("to_go", 3'd6, O_FLT);
        go = 1'b0;
        cyc("to_clear", 3'd1, O_RD);
`else
        for (int i = 0; i < 20; i++) cyc("no_timeout", 3'd1, O_RD);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
